// File: rtl/result_writer.sv
// Streams 32-bit result words out as single-word line writes, tags each word
// with its line sequence number and waits for every line completion before done.
module result_writer #(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_LMT+3:0]     base_addr,
  input  logic [LEN_W-1:0]        len,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    wr_req_almostfull,
  output logic                    wr_en,
  output logic                    wr_now,
  output logic                    wr_direct,
  output logic [ADDR_LMT+3:0]     wr_addr,
  output logic [CACHE_WIDTH-1:0]  wr_data,
  output logic [MDATA-1:0]        wr_mdata,
  input  logic                    wr_rsp0_valid,
  input  logic                    wr_rsp1_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int AW = ADDR_LMT + 4;
  localparam int LW = LEN_W + 1;
  localparam int CW = LEN_W + 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [AW-1:0]    cur_addr;
  logic [LEN_W-1:0] words_left;
  logic [MDATA-1:0] line_cnt;
  logic [LW-1:0]    lines_exp;
  logic [LW-1:0]    span;
  logic [CW-1:0]    cmp_cnt;
  logic [CW-1:0]    cmp_next;
  logic             accept;
  logic             last_word;
  logic             line_end;

  assign in_ready  = (state == RUN) && !wr_req_almostfull;
  assign accept    = in_valid && in_ready;
  assign last_word = (words_left == LEN_W'(1));
  // A last word sitting at offset 15 closes one line, not two.
  assign line_end  = (cur_addr[3:0] == 4'hF) || last_word;
  assign span      = LW'(base_addr[3:0]) + LW'(len) - LW'(1);
  assign cmp_next  = cmp_cnt + CW'(wr_rsp0_valid) + CW'(wr_rsp1_valid);
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign wr_direct = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      words_left <= '0;
      line_cnt   <= '0;
      lines_exp  <= '0;
      cmp_cnt    <= '0;
      wr_en      <= 1'b0;
      wr_now     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_mdata   <= '0;
    end else begin
      wr_en    <= accept;
      wr_now   <= accept && last_word;
      wr_addr  <= accept ? cur_addr : '0;
      wr_data  <= accept ? CACHE_WIDTH'(in_data) : '0;
      wr_mdata <= accept ? line_cnt : '0;

      case (state)
        IDLE: begin
          if (start) begin
            cur_addr   <= base_addr;
            words_left <= len;
            line_cnt   <= '0;
            cmp_cnt    <= '0;
            lines_exp  <= (span >> 4) + LW'(1);
            state      <= (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          cmp_cnt <= cmp_next;
          if (accept) begin
            cur_addr   <= cur_addr + AW'(1);
            words_left <= words_left - LEN_W'(1);
            if (line_end) line_cnt <= line_cnt + MDATA'(1);
            if (last_word) state <= DRAIN;
          end
        end
        DRAIN: begin
          cmp_cnt <= cmp_next;
          if (cmp_next >= CW'(lines_exp)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 Parameters SHALL be: ADDR_LMT, 20, cache-line address width; MDATA, 14, metadata width; CACHE_WIDTH, 512, line width; DATA_WIDTH, 32, word width; LEN_W, 16, length width.
REQ-002 clk  in  1  clock; all logic SHALL be rising-edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  one-cycle job launch pulse.
REQ-005 base_addr  in  ADDR_LMT+4  first word address; [3:0] is the word offset in the line.
REQ-006 len  in  LEN_W  job length in 32-bit words.
REQ-007 in_data  in  DATA_WIDTH  result word; in_valid  in  1  word present; in_ready  out  1  word accepted when in_valid & in_ready.
REQ-008 wr_req_almostfull  in  1  downstream request queue nearly full.
REQ-009 wr_en  out  1  word write strobe; wr_now  out  1  flush the partial line; wr_direct  out  1  constant 0.
REQ-010 wr_addr  out  ADDR_LMT+4  word address; wr_data  out  CACHE_WIDTH  {zeros, word}; wr_mdata  out  MDATA  line sequence tag.
REQ-011 wr_rsp0_valid, wr_rsp1_valid  in  1 each  write completions from channels 0 and 1.
REQ-012 busy  out  1  job active; done  out  1  one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-014 In IDLE, start SHALL latch base_addr and len, clear all counters, and compute lines_exp = ((base_addr[3:0] + len - 1) >> 4) + 1 using LEN_W+1-bit arithmetic.
REQ-015 In IDLE, start with len==0 SHALL go to DONE with no writes issued.
REQ-016 In IDLE, start with len>0 SHALL go to RUN.
REQ-017 Start SHALL be ignored in any state other than IDLE.
REQ-018 in_ready SHALL equal (state==RUN) & !wr_req_almostfull, combinationally.
REQ-019 Each accepted word SHALL produce, on the next cycle and for exactly one cycle, wr_en=1, wr_addr=cur_addr, wr_data={0, in_data} and wr_mdata=line_cnt[MDATA-1:0].
REQ-020 In that same cycle, wr_now SHALL be 1 exactly when the word is the job's last word, and 0 otherwise.
REQ-021 When no word is accepted, the next cycle SHALL have wr_en=0, wr_now=0, and wr_addr, wr_data and wr_mdata all 0.
REQ-022 cur_addr SHALL increment by 1 per accepted word, modulo 2^(ADDR_LMT+4).
REQ-023 line_cnt SHALL increment once per accepted word that has cur_addr[3:0]==15 or is the last word.
REQ-024 Under REQ-023, a last word at offset 15 SHALL count as one line, not two.
REQ-025 After the last word is accepted, the FSM SHALL go to DRAIN.
REQ-026 No further words SHALL be accepted until the next job.
REQ-027 The completion counter SHALL add wr_rsp0_valid + wr_rsp1_valid every cycle in RUN and in DRAIN, i.e. +2 when both are high.
REQ-028 DRAIN SHALL go to DONE on the first cycle in which cmp_cnt (including that cycle's additions) >= lines_exp.
REQ-029 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-030 busy SHALL be 1 in RUN and DRAIN, and 0 in IDLE and DONE.
REQ-031 Completions arriving in IDLE or DONE SHALL be ignored.
REQ-032 Back-to-back accepted words SHALL be allowed with no idle cycle between them, including across a line boundary.
REQ-033 Throughput SHALL be 1 word/cycle while almostfull is low.
REQ-034 Latency from acceptance to wr_en SHALL be exactly 1 cycle.

Reset
REQ-035 On rst, the FSM SHALL return to IDLE and all counters SHALL clear.
REQ-036 On rst, all outputs SHALL be 0: in_ready, wr_en, wr_now, wr_direct, wr_addr, wr_data, wr_mdata, busy and done.
REQ-037 rst SHALL take priority over every other input, including mid-job and in the same cycle as start.
REQ-038 No write SHALL be emitted in the cycle after rst.

Verification
REQ-039 base=0x40, len=16, in_valid held high -> wr_en for 16 consecutive cycles at addresses 0x40..0x4F, wr_now only on 0x4F, all wr_mdata=0; one rsp0 pulse -> done, one cycle.
REQ-040 base=0x3E, len=4 -> lines_exp=2; tags 0,0,1,1; wr_now only on the 4th word (0x41); rsp0 and rsp1 in the same cycle -> done on the next cycle.
REQ-041 wr_req_almostfull high for 3 cycles mid-job -> in_ready=0 and no wr_en for those cycles; the address sequence stays gap-free in value.
REQ-042 len=0 start -> done one cycle later, busy never 1, no wr_en.
REQ-043 rst asserted during RUN after 5 words -> next cycle all outputs 0 and state IDLE; a following job with base=0, len=1 -> a single wr_en with wr_now=1 at address 0.
REQ-044 base=0xFFFFFF, len=2 (ADDR_LMT=20) -> word addresses 0xFFFFFF then 0x000000, lines_exp=2, line tags 0 then 1.
